// File: rtl/div3_frame_accum.sv
// div3_frame_accum
//   Accumulates FRAME_LEN {quotient, remainder} pairs produced by a
//   divide-by-3 stage. Remainders are summed exactly and every time they
//   reach 3 a carry is folded into the quotient total. Each frame therefore
//   reports floor(sum(din)/3) and sum(din) mod 3.
//   Valid/ready handshake on both sides. The output is a single registered
//   slot. The next frame keeps accumulating while a result is still pending,
//   and stalls only at its final sample until that slot drains.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset, released synchronously
//   clr          synchronous flush of the frame in progress (output slot kept)
//   in_valid     in_quot/in_rem pair valid
//   in_ready     block can accept a pair (registered state and clr only)
//   in_quot      quotient from the divider, Q_WIDTH bits
//   in_rem       remainder from the divider (0..2; 3 is summed by the same rule)
//   out_valid    frame result valid
//   out_ready    consumer accepts the frame result
//   out_sum      frame quotient total including remainder carries
//   out_residue  frame sum mod 3
//   out_ovf      quotient accumulator wrapped at least once during the frame
module div3_frame_accum #(
    parameter int Q_WIDTH   = 15,
    parameter int ACC_WIDTH = 24,
    parameter int FRAME_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [Q_WIDTH-1:0]   in_quot,
    input  logic [1:0]           in_rem,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [1:0]           out_residue,
    output logic                 out_ovf
);

    localparam int                   CNT_WIDTH = $clog2(FRAME_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(FRAME_LEN - 1);

    // Frame-in-progress state
    logic [CNT_WIDTH-1:0] cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic [1:0]           res;
    logic                 ovf_acc;

    // Combinational datapath
    logic                 last_sample;
    logic                 in_fire;
    logic                 frame_close;
    logic [2:0]           r_new;
    logic                 carry;
    logic [1:0]           res_nxt;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic                 ovf_nxt;

    always_comb begin
        last_sample = (cnt == LAST_IDX);
        // A pending result only blocks the sample that would close the next
        // frame; earlier samples of that frame are accepted freely.
        in_ready    = !clr && !(out_valid && last_sample);
        in_fire     = in_valid && in_ready;
        frame_close = in_fire && last_sample;

        // Remainder accumulation: fold every full 3 into the quotient total.
        // With res <= 2 and in_rem <= 3 a single subtraction always suffices.
        r_new   = {1'b0, res} + {1'b0, in_rem};
        carry   = (r_new >= 3'd3);
        res_nxt = carry ? 2'(r_new - 3'd3) : r_new[1:0];

        acc_sum = {1'b0, acc}
                + (ACC_WIDTH + 1)'(in_quot)
                + (ACC_WIDTH + 1)'(carry);
        acc_nxt = acc_sum[ACC_WIDTH-1:0];
        ovf_nxt = ovf_acc || acc_sum[ACC_WIDTH];
    end

    // Frame accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            res     <= '0;
            ovf_acc <= 1'b0;
        end else if (clr || frame_close) begin
            cnt     <= '0;
            acc     <= '0;
            res     <= '0;
            ovf_acc <= 1'b0;
        end else if (in_fire) begin
            cnt     <= cnt + CNT_WIDTH'(1);
            acc     <= acc_nxt;
            res     <= res_nxt;
            ovf_acc <= ovf_nxt;
        end
    end

    // Output slot. Loading a freshly closed frame takes priority over the
    // drain, so a close coinciding with a consume keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_residue <= '0;
            out_ovf     <= 1'b0;
        end else if (frame_close) begin
            out_valid   <= 1'b1;
            out_sum     <= acc_nxt;
            out_residue <= res_nxt;
            out_ovf     <= ovf_nxt;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div3_frame_accum.sv
// Testbench for div3_frame_accum (FRAME_LEN=4, ACC_WIDTH=16, Q_WIDTH=15).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_div3_frame_accum;

    localparam int QW = 15;
    localparam int AW = 16;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [QW-1:0] in_quot;
    logic [1:0]    in_rem;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [1:0]    out_residue;
    logic          out_ovf;

    div3_frame_accum #(
        .Q_WIDTH  (QW),
        .ACC_WIDTH(AW),
        .FRAME_LEN(FL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_quot    (in_quot),
        .in_rem     (in_rem),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_residue(out_residue),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One frame of four pairs plus its expected result.
    typedef struct {
        logic [FL-1:0][QW-1:0] q;
        logic [FL-1:0][1:0]    r;
        logic [AW-1:0]         sum;
        logic [1:0]            res;
        logic                  ovf;
    } vec_t;

    function automatic vec_t mk(input int q0, input int q1, input int q2, input int q3,
                                input int r0, input int r1, input int r2, input int r3,
                                input int s, input int rs, input int o);
        vec_t v;
        v.q[0] = QW'(q0); v.q[1] = QW'(q1); v.q[2] = QW'(q2); v.q[3] = QW'(q3);
        v.r[0] = 2'(r0);  v.r[1] = 2'(r1);  v.r[2] = 2'(r2);  v.r[3] = 2'(r3);
        v.sum  = AW'(s);
        v.res  = 2'(rs);
        v.ovf  = 1'(o);
        return v;
    endfunction

    typedef struct {
        logic [AW-1:0] sum;
        logic [1:0]    res;
        logic          ovf;
    } fr_t;

    // Called on a falling edge; returns on the falling edge after the pair
    // has been taken (or after giving up waiting for in_ready).
    task automatic send(input int q, input int r);
        int n = 0;
        in_valid = 1'b1;
        in_quot  = QW'(q);
        in_rem   = 2'(r);
        #1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_wait_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[7];
        fr_t   expq[$];
        fr_t   e;
        longint s_acc;
        longint tot;
        int    n_in;
        int    frames;
        int    q;
        int    r;
        int    din;

        tbl[0] = mk(5, 33, 2, 0,             1, 1, 1, 2,  41,    2, 0);
        tbl[1] = mk(21845, 21845, 21845, 21845, 0, 0, 0, 0, 21844, 0, 1);
        tbl[2] = mk(1, 1, 1, 1,              0, 0, 0, 0,  4,     0, 0);
        tbl[3] = mk(32767, 32767, 32767, 32767, 2, 2, 2, 2, 65534, 2, 1);
        tbl[4] = mk(0, 0, 0, 0,              3, 3, 3, 3,  4,     0, 0);
        tbl[5] = mk(0, 0, 0, 0,              0, 0, 0, 0,  0,     0, 0);
        tbl[6] = mk(3, 0, 100, 7,            2, 1, 0, 2,  111,   2, 0);

        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_quot   = '0;
        in_rem    = '0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_out_sum",     32'(out_sum),     32'd0);
        chk("rst_out_residue", 32'(out_residue), 32'd0);
        chk("rst_out_ovf",     32'(out_ovf),     32'd0);
        chk("rst_in_ready",    32'(in_ready),    32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven frames with out_ready held high
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < FL; k++) begin
                send(int'(tbl[i].q[k]), int'(tbl[i].r[k]));
                if (k == FL - 2)
                    chk($sformatf("tbl%0d_early_valid", i), 32'(out_valid), 32'd0);
            end
            chk($sformatf("tbl%0d_valid", i),   32'(out_valid),   32'd1);
            chk($sformatf("tbl%0d_sum", i),     32'(out_sum),     32'(tbl[i].sum));
            chk($sformatf("tbl%0d_residue", i), 32'(out_residue), 32'(tbl[i].res));
            chk($sformatf("tbl%0d_ovf", i),     32'(out_ovf),     32'(tbl[i].ovf));
            @(negedge clk);
            chk($sformatf("tbl%0d_pulse_end", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: second frame stalls only at its last sample
        out_ready = 1'b0;
        for (int k = 0; k < FL; k++) send(1, 1);
        chk("bp_f1_valid", 32'(out_valid),   32'd1);
        chk("bp_f1_sum",   32'(out_sum),     32'd5);
        chk("bp_f1_res",   32'(out_residue), 32'd1);
        for (int k = 0; k < FL - 1; k++) send(1, 1);
        in_valid = 1'b1;
        in_quot  = QW'(1);
        in_rem   = 2'd1;
        #1;
        chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_valid",    32'(out_valid), 32'd1);
        chk("bp_hold_sum",      32'(out_sum),   32'd5);
        out_ready = 1'b1;
        #1;
        chk("bp_no_comb_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp_drained_valid", 32'(out_valid), 32'd0);
        chk("bp_resume_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_f2_valid", 32'(out_valid),   32'd1);
        chk("bp_f2_sum",   32'(out_sum),     32'd5);
        chk("bp_f2_res",   32'(out_residue), 32'd1);
        @(negedge clk);
        chk("bp_f2_pulse_end", 32'(out_valid), 32'd0);

        // clr flushes the partial frame and rejects the concurrent pair
        send(10, 2);
        send(10, 2);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_quot  = QW'(10);
        in_rem   = 2'd2;
        #1;
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < FL; k++) send(3, 0);
        chk("clr_valid",   32'(out_valid),   32'd1);
        chk("clr_sum",     32'(out_sum),     32'd12);
        chk("clr_residue", 32'(out_residue), 32'd0);
        @(negedge clk);

        // clr leaves a pending result untouched
        out_ready = 1'b0;
        for (int k = 0; k < FL; k++) send(2, 0);
        send(7, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_keep_valid", 32'(out_valid), 32'd1);
        chk("clr_keep_sum",   32'(out_sum),   32'd8);
        out_ready = 1'b1;
        @(negedge clk);

        // Asynchronous reset with a pending result and a partial frame
        out_ready = 1'b0;
        for (int k = 0; k < FL; k++) send(1, 1);
        for (int k = 0; k < 3; k++) send(4, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid",   32'(out_valid),   32'd0);
        chk("arst_sum",     32'(out_sum),     32'd0);
        chk("arst_residue", 32'(out_residue), 32'd0);
        chk("arst_ovf",     32'(out_ovf),     32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < FL; k++) begin
            send(2, 2);
            if (k == FL - 2)
                chk("arst_no_partial", 32'(out_valid), 32'd0);
        end
        chk("arst_f_valid",   32'(out_valid),   32'd1);
        chk("arst_f_sum",     32'(out_sum),     32'd10);
        chk("arst_f_residue", 32'(out_residue), 32'd2);
        @(negedge clk);

        // Random traffic against a sum-based frame model
        s_acc  = 0;
        n_in   = 0;
        frames = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) == 0) begin
                q = int'($urandom_range(0, 32767));
                r = int'($urandom_range(0, 3));
            end else begin
                din = int'($urandom_range(0, 65535));
                q   = din / 3;
                r   = din % 3;
            end
            in_quot = QW'(q);
            in_rem  = 2'(r);
            #1;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("rand_unexpected_frame", 32'(out_valid), 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk($sformatf("rand_f%0d_sum", frames),     32'(out_sum),     32'(e.sum));
                    chk($sformatf("rand_f%0d_residue", frames), 32'(out_residue), 32'(e.res));
                    chk($sformatf("rand_f%0d_ovf", frames),     32'(out_ovf),     32'(e.ovf));
                    frames++;
                end
            end
            if (clr) begin
                s_acc = 0;
                n_in  = 0;
            end else if (in_valid && in_ready) begin
                s_acc += 3 * longint'(q) + longint'(r);
                n_in++;
                if (n_in == FL) begin
                    tot   = s_acc / 3;
                    e.sum = AW'(tot);
                    e.res = 2'(s_acc % 3);
                    e.ovf = (tot >= (longint'(1) << AW));
                    expq.push_back(e);
                    s_acc = 0;
                    n_in  = 0;
                end
            end
            @(negedge clk);
        end

        // Drain remaining results
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("drain_unexpected_frame", 32'(out_valid), 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk($sformatf("drain_f%0d_sum", frames),     32'(out_sum),     32'(e.sum));
                    chk($sformatf("drain_f%0d_residue", frames), 32'(out_residue), 32'(e.res));
                    chk($sformatf("drain_f%0d_ovf", frames),     32'(out_ovf),     32'(e.ovf));
                    frames++;
                end
            end
            @(negedge clk);
        end
        chk("rand_lost_frames", 32'(expq.size()), 32'd0);
        chk("rand_frames_seen", 32'(frames >= 20), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
